// File: rtl/vproc_pkg.sv
// ---------------------------------------------------------------------------
// vproc_pkg
// Shared definitions for the vector-instruction decode/sequencer slice:
//   - 4-bit opcode encodings
//   - bit positions inside the one-hot op vector
//   - bit positions inside the ctrl_path vector
//   - FSM state type and state encodings
// ---------------------------------------------------------------------------
package vproc_pkg;

  // Opcode encodings (instr[15:12]). 1001..1110 are undefined.
  localparam logic [3:0] OPC_VADD = 4'b0000;
  localparam logic [3:0] OPC_VDOT = 4'b0001;
  localparam logic [3:0] OPC_SMUL = 4'b0010;
  localparam logic [3:0] OPC_SST  = 4'b0011;
  localparam logic [3:0] OPC_VLD  = 4'b0100;
  localparam logic [3:0] OPC_VST  = 4'b0101;
  localparam logic [3:0] OPC_SLL  = 4'b0110;
  localparam logic [3:0] OPC_SLH  = 4'b0111;
  localparam logic [3:0] OPC_J    = 4'b1000;
  localparam logic [3:0] OPC_NOP  = 4'b1111;

  // One-hot op vector {VADD,VDOT,SMUL,SST,VLD,VST,SLL,SLH,J,NOP}, MSB first.
  localparam int OP_W    = 10;
  localparam int OP_VADD = 9;
  localparam int OP_VDOT = 8;
  localparam int OP_SMUL = 7;
  localparam int OP_SST  = 6;
  localparam int OP_VLD  = 5;
  localparam int OP_VST  = 4;
  localparam int OP_SLL  = 3;
  localparam int OP_SLH  = 2;
  localparam int OP_J    = 1;
  localparam int OP_NOP  = 0;

  // Control-path vector {fpu,ld,sst,vst,sll_slh,jmp,nop}, MSB first.
  localparam int CP_W       = 7;
  localparam int CP_FPU     = 6;
  localparam int CP_LD      = 5;
  localparam int CP_SST     = 4;
  localparam int CP_VST     = 3;
  localparam int CP_SLL_SLH = 2;
  localparam int CP_JMP     = 1;
  localparam int CP_NOP     = 0;

  // Sequencer FSM. Plain constants keep the encoding visible to older tools.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_ISSUE = 1'b1;

endpackage : vproc_pkg

// File: rtl/vdecode_comb.sv
// ---------------------------------------------------------------------------
// vdecode_comb
// Purely combinational opcode decoder.
// Ports:
//   instr_i       in   [15:3] opcode [15:12] and register fields [11:3]
//   op_o          out  10     one-hot op {VADD,VDOT,SMUL,SST,VLD,VST,SLL,SLH,J,NOP}
//   ctrl_path_o   out  7      {fpu,ld,sst,vst,sll_slh,jmp,nop}
//   sreadb_o      out  3      scalar read port B register select
//   vreada_o      out  3      vector read port A register select
//   is_vector_o   out  1      op issues one beat per vector element
//   is_illegal_o  out  1      opcode is undefined
// ---------------------------------------------------------------------------
module vdecode_comb
  import vproc_pkg::*;
(
  input  logic [15:3]     instr_i,
  output logic [OP_W-1:0] op_o,
  output logic [CP_W-1:0] ctrl_path_o,
  output logic [2:0]      sreadb_o,
  output logic [2:0]      vreada_o,
  output logic            is_vector_o,
  output logic            is_illegal_o
);

  logic [3:0] opcode;
  logic [2:0] fld_a;  // instr[11:9]
  logic [2:0] fld_b;  // instr[8:6]
  logic [2:0] fld_c;  // instr[5:3]

  assign opcode = instr_i[15:12];
  assign fld_a  = instr_i[11:9];
  assign fld_b  = instr_i[8:6];
  assign fld_c  = instr_i[5:3];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned; that is what keeps this block from inferring latches.
    op_o         = '0;
    is_illegal_o = 1'b0;
    unique case (opcode)
      OPC_VADD: op_o[OP_VADD] = 1'b1;
      OPC_VDOT: op_o[OP_VDOT] = 1'b1;
      OPC_SMUL: op_o[OP_SMUL] = 1'b1;
      OPC_SST:  op_o[OP_SST]  = 1'b1;
      OPC_VLD:  op_o[OP_VLD]  = 1'b1;
      OPC_VST:  op_o[OP_VST]  = 1'b1;
      OPC_SLL:  op_o[OP_SLL]  = 1'b1;
      OPC_SLH:  op_o[OP_SLH]  = 1'b1;
      OPC_J:    op_o[OP_J]    = 1'b1;
      OPC_NOP:  op_o[OP_NOP]  = 1'b1;
      default:  is_illegal_o  = 1'b1;
    endcase
  end

  // Control paths are straight ORs of the one-hot op bits; an illegal
  // opcode yields all-zero op and therefore all-zero ctrl_path.
  assign ctrl_path_o[CP_FPU]     = op_o[OP_VADD] | op_o[OP_VDOT] | op_o[OP_SMUL];
  assign ctrl_path_o[CP_LD]      = op_o[OP_VLD];
  assign ctrl_path_o[CP_SST]     = op_o[OP_SST];
  assign ctrl_path_o[CP_VST]     = op_o[OP_VST];
  assign ctrl_path_o[CP_SLL_SLH] = op_o[OP_SLL] | op_o[OP_SLH];
  assign ctrl_path_o[CP_JMP]     = op_o[OP_J];
  assign ctrl_path_o[CP_NOP]     = op_o[OP_NOP];

  // Memory ops address their scalar operand with the middle field; the FPU
  // ops take their vector operand from the middle field as well.
  assign sreadb_o = (op_o[OP_VLD] | op_o[OP_VST] | op_o[OP_SST]) ? fld_b : fld_c;
  assign vreada_o = ctrl_path_o[CP_FPU] ? fld_b : fld_a;

  assign is_vector_o = op_o[OP_VADD] | op_o[OP_VDOT] | op_o[OP_VLD] | op_o[OP_VST];

endmodule : vdecode_comb

// File: rtl/vdecode_seq.sv
// ---------------------------------------------------------------------------
// vdecode_seq
// Accepts one 16-bit instruction at a time, decodes it and issues it as a
// stream of registered beats: VLEN beats for vector-class ops, one beat for
// everything else. Undefined opcodes are swallowed with a one-cycle pulse.
// Parameters:
//   VLEN    elements per vector instruction (power of two, 2..16)
//   ELEM_W  element-index width, derived from VLEN
// Ports:
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous active-high reset
//   instr_valid  in   1       upstream offers instr
//   instr        in   16      instruction word
//   instr_ready  out  1       instr is accepted this cycle
//   issue_valid  out  1       a decoded beat is presented
//   issue_ready  in   1       downstream takes the current beat
//   op           out  10      one-hot opcode of the current beat
//   ctrl_path    out  7       control-path selects of the current beat
//   sreadb       out  3       scalar read port B select
//   vreada       out  3       vector read port A select
//   elem_idx     out  ELEM_W  element index of the current beat
//   last_elem    out  1       current beat is the instruction's final beat
//   illegal      out  1       pulse: an undefined opcode was consumed
// ---------------------------------------------------------------------------
module vdecode_seq
  import vproc_pkg::*;
#(
  parameter  int VLEN   = 4,
  localparam int ELEM_W = $clog2(VLEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [9:0]        op,
  output logic [6:0]        ctrl_path,
  output logic [2:0]        sreadb,
  output logic [2:0]        vreada,
  output logic [ELEM_W-1:0] elem_idx,
  output logic              last_elem,
  output logic              illegal
);

  localparam logic [ELEM_W-1:0] LAST_IDX = ELEM_W'(VLEN - 1);

  // ---- decode ------------------------------------------------------------
  logic [OP_W-1:0] dec_op;
  logic [CP_W-1:0] dec_ctrl;
  logic [2:0]      dec_sreadb;
  logic [2:0]      dec_vreada;
  logic            dec_is_vector;
  logic            dec_is_illegal;

  vdecode_comb u_decode (
    .instr_i      (instr[15:3]),
    .op_o         (dec_op),
    .ctrl_path_o  (dec_ctrl),
    .sreadb_o     (dec_sreadb),
    .vreada_o     (dec_vreada),
    .is_vector_o  (dec_is_vector),
    .is_illegal_o (dec_is_illegal)
  );

  // instr[2:0] carries no field this block uses.
  logic unused_instr_lsbs;
  assign unused_instr_lsbs = ^instr[2:0];

  // ---- state -------------------------------------------------------------
  state_t            state_q,     state_d;
  logic [OP_W-1:0]   op_q,        op_d;
  logic [CP_W-1:0]   ctrl_q,      ctrl_d;
  logic [2:0]        sreadb_q,    sreadb_d;
  logic [2:0]        vreada_q,    vreada_d;
  logic [ELEM_W-1:0] elem_idx_q,  elem_idx_d;
  logic              is_vec_q,    is_vec_d;
  logic              illegal_q,   illegal_d;

  logic accept;     // instruction handshake this cycle
  logic beat_done;  // issue handshake this cycle

  // The ISSUE state is exactly "a beat is presented", so issue_valid comes
  // straight off the state register.
  assign issue_valid = (state_q == ST_ISSUE);
  assign last_elem   = issue_valid && (!is_vec_q || (elem_idx_q == LAST_IDX));
  assign beat_done   = issue_valid && issue_ready;
  // Ready on the final beat's handshake lets the next instruction load
  // behind it with no bubble.
  assign instr_ready = (state_q == ST_IDLE) || (beat_done && last_elem);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ctrl_d     = ctrl_q;
    sreadb_d   = sreadb_q;
    vreada_d   = vreada_q;
    elem_idx_d = elem_idx_q;
    is_vec_d   = is_vec_q;
    illegal_d  = 1'b0;

    // Retire the current beat. elem_idx only advances on non-final beats,
    // so it can never step past LAST_IDX.
    if (beat_done) begin
      if (last_elem) begin
        state_d = ST_IDLE;
      end else begin
        elem_idx_d = elem_idx_q + ELEM_W'(1);
      end
    end

    // A new instruction overrides the retire decision above. An undefined
    // opcode is consumed but never loaded, so the FSM settles in IDLE.
    if (accept) begin
      if (dec_is_illegal) begin
        illegal_d = 1'b1;
      end else begin
        state_d    = ST_ISSUE;
        op_d       = dec_op;
        ctrl_d     = dec_ctrl;
        sreadb_d   = dec_sreadb;
        vreada_d   = dec_vreada;
        is_vec_d   = dec_is_vector;
        elem_idx_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      ctrl_q     <= '0;
      sreadb_q   <= '0;
      vreada_q   <= '0;
      elem_idx_q <= '0;
      is_vec_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ctrl_q     <= ctrl_d;
      sreadb_q   <= sreadb_d;
      vreada_q   <= vreada_d;
      elem_idx_q <= elem_idx_d;
      is_vec_q   <= is_vec_d;
      illegal_q  <= illegal_d;
    end
  end

  assign op        = op_q;
  assign ctrl_path = ctrl_q;
  assign sreadb    = sreadb_q;
  assign vreada    = vreada_q;
  assign elem_idx  = elem_idx_q;
  assign illegal   = illegal_q;

endmodule : vdecode_seq

// File: tb/tb_vdecode_seq.sv
// ---------------------------------------------------------------------------
// tb_vdecode_seq
// Directed bench for vdecode_seq. Two instances share clk/rst: u_dut4
// (VLEN=4) carries scenarios 1-5, u_dut8 (VLEN=8) carries scenario 6.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after.
// ---------------------------------------------------------------------------
module tb_vdecode_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // VLEN=4 instance
  logic        iv4 = 1'b0;
  logic [15:0] in4 = '0;
  logic        rdy4 = 1'b0;
  logic        ir4, vld4, last4, ill4;
  logic [9:0]  op4;
  logic [6:0]  cp4;
  logic [2:0]  sb4, va4;
  logic [1:0]  ei4;

  // VLEN=8 instance
  logic        iv8 = 1'b0;
  logic [15:0] in8 = '0;
  logic        rdy8 = 1'b0;
  logic        ir8, vld8, last8, ill8;
  logic [9:0]  op8;
  logic [6:0]  cp8;
  logic [2:0]  sb8, va8;
  logic [2:0]  ei8;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vdecode_seq #(.VLEN(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .instr_valid(iv4), .instr(in4), .instr_ready(ir4),
    .issue_valid(vld4), .issue_ready(rdy4),
    .op(op4), .ctrl_path(cp4), .sreadb(sb4), .vreada(va4),
    .elem_idx(ei4), .last_elem(last4), .illegal(ill4)
  );

  vdecode_seq #(.VLEN(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .instr_valid(iv8), .instr(in8), .instr_ready(ir8),
    .issue_valid(vld8), .issue_ready(rdy8),
    .op(op8), .ctrl_path(cp8), .sreadb(sb8), .vreada(va8),
    .elem_idx(ei8), .last_elem(last8), .illegal(ill8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    #2;
    check("rst_issue_valid", 32'(vld4),  32'(1'b0));
    check("rst_op",          32'(op4),   32'(10'b0));
    check("rst_ctrl",        32'(cp4),   32'(7'b0));
    check("rst_sreadb",      32'(sb4),   32'(3'b0));
    check("rst_vreada",      32'(va4),   32'(3'b0));
    check("rst_elem_idx",    32'(ei4),   32'(2'b0));
    check("rst_last",        32'(last4), 32'(1'b0));
    check("rst_illegal",     32'(ill4),  32'(1'b0));
    tick();
    tick();
    rst = 1'b0;
    tick();
    #1;
    check("post_rst_ready", 32'(ir4), 32'(1'b1));

    // ---------------- scenario 1: VADD, 4 beats ----------------
    iv4 = 1'b1; in4 = 16'h0000; rdy4 = 1'b1;
    #1;
    check("s1_accept_ready", 32'(ir4), 32'(1'b1));
    tick();
    iv4 = 1'b0;
    #1;
    check("s1_op",   32'(op4), 32'(10'b1000000000));
    check("s1_ctrl", 32'(cp4), 32'(7'b1000000));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("s1_valid_%0d", k), 32'(vld4),  32'(1'b1));
      check($sformatf("s1_idx_%0d", k),   32'(ei4),   32'(k));
      check($sformatf("s1_last_%0d", k),  32'(last4), 32'(k == 3));
      tick();
      #1;
    end
    check("s1_done_valid", 32'(vld4), 32'(1'b0));

    // ---------------- scenario 2: SST, single beat ----------------
    iv4 = 1'b1; in4 = 16'h3A5C;
    tick();
    iv4 = 1'b0;
    #1;
    check("s2_valid",  32'(vld4),  32'(1'b1));
    check("s2_op",     32'(op4),   32'(10'b0001000000));
    check("s2_sreadb", 32'(sb4),   32'(3'b001));
    check("s2_vreada", 32'(va4),   32'(3'b101));
    check("s2_last",   32'(last4), 32'(1'b1));
    check("s2_ctrl",   32'(cp4),   32'(7'b0010000));
    check("s2_idx",    32'(ei4),   32'(0));
    tick();
    #1;
    check("s2_done_valid", 32'(vld4), 32'(1'b0));

    // ---------------- scenario 3: VLD then J back-to-back ----------------
    iv4 = 1'b1; in4 = 16'h4000;
    tick();
    in4 = 16'h8000;  // J held valid; must be ignored until VLD's last beat
    #1;
    check("s3_vld_op",   32'(op4), 32'(10'b0000100000));
    check("s3_vld_ctrl", 32'(cp4), 32'(7'b0100000));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("s3_valid_%0d", k), 32'(vld4), 32'(1'b1));
      check($sformatf("s3_idx_%0d", k),   32'(ei4),  32'(k < 4 ? k : 0));
      if (k < 4) begin
        check($sformatf("s3_ready_%0d", k), 32'(ir4), 32'(k == 3));
      end
      tick();
      if (k == 3) begin
        iv4 = 1'b0;
        #1;
        check("s3_j_op",   32'(op4),   32'(10'b0000000010));
        check("s3_j_ctrl", 32'(cp4),   32'(7'b0000010));
        check("s3_j_last", 32'(last4), 32'(1'b1));
      end else begin
        #1;
      end
    end
    check("s3_done_valid", 32'(vld4), 32'(1'b0));

    // ---------------- scenario 4: VST with a 3-cycle stall on beat 1 -------
    iv4 = 1'b1; in4 = 16'h5000;
    tick();
    iv4 = 1'b0;
    tick();
    rdy4 = 1'b0;
    iv4 = 1'b1; in4 = 16'hF000;  // NOP offered during stall; must be ignored
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("s4_stall_valid_%0d", k), 32'(vld4), 32'(1'b1));
      check($sformatf("s4_stall_idx_%0d", k),   32'(ei4),  32'(1));
      check($sformatf("s4_stall_op_%0d", k),    32'(op4),  32'(10'b0000010000));
      check($sformatf("s4_stall_ctrl_%0d", k),  32'(cp4),  32'(7'b0001000));
      check($sformatf("s4_stall_ready_%0d", k), 32'(ir4),  32'(1'b0));
      tick();
      #1;
    end
    iv4 = 1'b0; rdy4 = 1'b1;
    #1;
    check("s4_resume_idx", 32'(ei4), 32'(1));
    tick();
    #1;
    check("s4_idx_2", 32'(ei4), 32'(2));
    tick();
    #1;
    check("s4_idx_3",  32'(ei4),   32'(3));
    check("s4_last_3", 32'(last4), 32'(1'b1));
    tick();
    #1;
    check("s4_done_valid", 32'(vld4), 32'(1'b0));

    // ---------------- scenario 5: illegal opcode 1010 ----------------
    iv4 = 1'b1; in4 = 16'hA000;
    tick();
    iv4 = 1'b0;
    #1;
    check("s5_illegal_hi", 32'(ill4), 32'(1'b1));
    check("s5_valid",      32'(vld4), 32'(1'b0));
    check("s5_ready",      32'(ir4),  32'(1'b1));
    tick();
    #1;
    check("s5_illegal_lo", 32'(ill4), 32'(1'b0));
    check("s5_valid_2",    32'(vld4), 32'(1'b0));

    // ---------------- scenario 6: reset mid-VDOT, VLEN=8 ----------------
    iv8 = 1'b1; in8 = 16'h1000; rdy8 = 1'b1;
    tick();
    iv8 = 1'b0;
    tick();
    tick();
    #1;
    check("s6_pre_idx",   32'(ei8),  32'(2));
    check("s6_pre_valid", 32'(vld8), 32'(1'b1));
    #2;
    rst = 1'b1;   // asserted mid-cycle, away from any edge
    #1;
    check("s6_rst_valid", 32'(vld8),  32'(1'b0));
    check("s6_rst_op",    32'(op8),   32'(10'b0));
    check("s6_rst_ctrl",  32'(cp8),   32'(7'b0));
    check("s6_rst_idx",   32'(ei8),   32'(3'b0));
    check("s6_rst_last",  32'(last8), 32'(1'b0));
    tick();
    rst = 1'b0;
    tick();
    #1;
    check("s6_post_valid", 32'(vld8), 32'(1'b0));
    check("s6_post_ready", 32'(ir8),  32'(1'b1));
    iv8 = 1'b1; in8 = 16'h6000;
    tick();
    iv8 = 1'b0;
    #1;
    check("s6_sll_valid", 32'(vld8),  32'(1'b1));
    check("s6_sll_idx",   32'(ei8),   32'(0));
    check("s6_sll_op",    32'(op8),   32'(10'b0000001000));
    check("s6_sll_ctrl",  32'(cp8),   32'(7'b0000100));
    check("s6_sll_last",  32'(last8), 32'(1'b1));
    tick();
    #1;
    check("s6_done_valid", 32'(vld8), 32'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_vdecode_seq
